la_step_reporter: RTL and testbench
===================================

LA_STEP_REPORTER -- requirements
Module: la_step_reporter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, number of cycles each phase is held on the pads; legal range 1..255.
REQ-002 SHALL have port clock, input, 1, single clock for all state.
REQ-003 SHALL have port resetb, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port la_step_i, input, 6, step number requested by firmware over the LA.
REQ-005 SHALL have port la_status_i, input, 2, status code shown while the step is presented.
REQ-006 SHALL have port la_req_i, input, 1, level request from firmware; rising edge starts a report.
REQ-007 SHALL have port io_out_o, output, 38, user pad outputs.
REQ-008 SHALL have port io_oeb_o, output, 38, pad output-enable bar.
REQ-009 SHALL have port la_ack_o, output, 1, report complete, returned to firmware.
REQ-010 SHALL have port la_err_o, output, 1, sticky sequence/protocol error.
REQ-011 SHALL have port la_last_o, output, 6, last step captured.
REQ-012 SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL drive io_oeb_o[25:20] and io_oeb_o[37:36] to 0 and every other io_oeb_o bit to 1, constant, including during reset.
REQ-014 SHALL drive io_out_o[25:20] from the step register and io_out_o[37:36] from the status register; all other io_out_o bits SHALL be 0.
REQ-015 SHALL register la_req_i into req_q each cycle; a rising edge is la_req_i=1 and req_q=0.
REQ-016 SHALL implement states IDLE, SHOW, CLEAR, DONE.
REQ-017 In IDLE, on a rising edge, SHALL capture la_step_i into the step register and la_status_i into the status register (00 replaced by 01), load the hold counter with HOLD_CYCLES-1, and enter SHOW; the pads change on that same clock edge.
REQ-018 In SHOW, SHALL decrement the counter each cycle; when it reaches 0, SHALL set status to 00, reload HOLD_CYCLES-1, and enter CLEAR, so the step code plus nonzero status is visible for exactly HOLD_CYCLES cycles.
REQ-019 In CLEAR, SHALL hold status 00 for HOLD_CYCLES cycles, then enter DONE with la_ack_o=1.
REQ-020 In DONE, SHALL keep la_ack_o=1 until la_req_i is sampled 0, then return to IDLE with la_ack_o=0 on that edge; if la_req_i is already 0 on DONE entry, ack SHALL be a single-cycle pulse.
REQ-021 io_out_o[25:20] SHALL keep the last captured step after the sequence completes until the next capture; status SHALL be 00 in IDLE, CLEAR, DONE.
REQ-022 Sequence check: at capture, if la_step_i differs from (la_last_o+1) mod 64, SHALL set la_err_o; la_last_o SHALL then take the captured step regardless (63 -> 0 wrap is legal).
REQ-023 A rising edge of la_req_i seen in SHOW, CLEAR or DONE SHALL be ignored for capture and SHALL set la_err_o.
REQ-024 la_step_i and la_status_i changes outside a capture edge SHALL have no effect on the pads.
REQ-025 la_err_o SHALL be cleared only by reset.

Reset
REQ-026 On resetb=0, SHALL asynchronously force state IDLE, step register 0, status 00, counter 0, req_q 0, la_ack_o 0, la_err_o 0, la_last_o 0, busy_o 0; io_out_o SHALL read all zeros.
REQ-027 Reset asserted mid-SHOW or mid-CLEAR SHALL abort immediately with no ack; after release, la_req_i held high SHALL NOT start a report until it falls and rises again.

Verification
REQ-028 HOLD_CYCLES=4, steps 1..32 in order, each with status 11, req held until ack -> per step: io[25:20]=n and io[37:36]=11 for 4 cycles, then 00 for 4 cycles, ack high; la_err_o stays 0; la_last_o ends at 32.
REQ-029 Steps 1, 2, 4 -> la_err_o rises at capture of 4 and stays high; pads still show 4; la_last_o=4.
REQ-030 la_status_i=00 at capture -> io[37:36]=01 during SHOW.
REQ-031 req pulsed low-high during SHOW -> no new capture, la_err_o=1, current sequence completes normally.
REQ-032 la_last_o=63, next step 0 -> no error; step 1 next -> no error.
REQ-033 resetb low two cycles into SHOW with req held high -> outputs return to reset values, no ack; after release, no report until req falls and rises.

Source files
------------

// File: rtl/la_step_reporter.sv
// Step/status reporter: presents a firmware-requested step code and status
// on user pads for a fixed hold time, then clears status and acknowledges.
module la_step_reporter #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic [5:0]  la_step_i,
  input  logic [1:0]  la_status_i,
  input  logic        la_req_i,
  output logic [37:0] io_out_o,
  output logic [37:0] io_oeb_o,
  output logic        la_ack_o,
  output logic        la_err_o,
  output logic [5:0]  la_last_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    CLEAR,
    DONE
  } state_e;

  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] step_q, step_d;
  logic [1:0] status_q, status_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_q, arm_q, arm_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic [5:0] last_q, last_d;
  logic       rise;

  // arm_q blocks a request that was already high when reset released
  assign rise = la_req_i & ~req_q & arm_q;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    err_d    = err_q;
    last_d   = last_q;
    arm_d    = arm_q | ~la_req_i;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          step_d   = la_step_i;
          status_d = (la_status_i == 2'b00) ? 2'b01 : la_status_i;
          cnt_d    = RELOAD;
          last_d   = la_step_i;
          state_d  = SHOW;
          if (la_step_i != 6'(last_q + 6'd1)) err_d = 1'b1;
        end
      end
      SHOW: begin
        if (rise) err_d = 1'b1;
        if (cnt_q == 8'd0) begin
          status_d = 2'b00;
          cnt_d    = RELOAD;
          state_d  = CLEAR;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CLEAR: begin
        if (rise) err_d = 1'b1;
        if (cnt_q == 8'd0) begin
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        if (rise) err_d = 1'b1;
        if (!la_req_i) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      step_q   <= '0;
      status_q <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      arm_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      req_q    <= la_req_i;
      arm_q    <= arm_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      last_q   <= last_d;
    end
  end

  assign io_out_o  = {status_q, 10'd0, step_q, 20'd0};
  assign io_oeb_o  = {2'b00, 10'h3FF, 6'd0, 20'hFFFFF};
  assign la_ack_o  = ack_q;
  assign la_err_o  = err_q;
  assign la_last_o = last_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_la_step_reporter.sv
// Bench for la_step_reporter: scoreboard of expected reports popped on
// each ack rise, plus per-cycle pad checks while a report is presented.
module tb_la_step_reporter;

  localparam int H = 4;

  logic        clock;
  logic        resetb;
  logic [5:0]  la_step_i;
  logic [1:0]  la_status_i;
  logic        la_req_i;
  logic [37:0] io_out_o;
  logic [37:0] io_oeb_o;
  logic        la_ack_o;
  logic        la_err_o;
  logic [5:0]  la_last_o;
  logic        busy_o;

  la_step_reporter #(.HOLD_CYCLES(H)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .la_step_i  (la_step_i),
    .la_status_i(la_status_i),
    .la_req_i   (la_req_i),
    .io_out_o   (io_out_o),
    .io_oeb_o   (io_oeb_o),
    .la_ack_o   (la_ack_o),
    .la_err_o   (la_err_o),
    .la_last_o  (la_last_o),
    .busy_o     (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] step;
    logic       err;
  } item_t;

  item_t      sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [5:0] last_m = '0;
  logic       err_m = 1'b0;
  logic       ack_prev = 1'b0;
  logic [37:0] oeb_exp;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (la_ack_o && !ack_prev) begin
      if (sb.size() == 0) begin
        check("spurious_ack", 1, 0);
      end else begin
        item_t it;
        it = sb.pop_front();
        check("ack_last", la_last_o, it.step);
        check("ack_step", io_out_o[25:20], it.step);
        check("ack_err", la_err_o, it.err);
      end
    end
    ack_prev <= la_ack_o;
  end

  task automatic report(input logic [5:0] step, input logic [1:0] st,
                        input bit pulse, input bit early);
    logic [1:0] exp_st;
    logic       cap_err;
    item_t      it;
    exp_st  = (st == 2'b00) ? 2'b01 : st;
    cap_err = err_m | (step != 6'(last_m + 6'd1));
    err_m   = cap_err;
    last_m  = step;
    if (pulse) err_m = 1'b1;
    it.step = step;
    it.err  = err_m;
    sb.push_back(it);
    @(posedge clock); #1;
    la_step_i   = step;
    la_status_i = st;
    la_req_i    = 1'b1;
    @(posedge clock);
    for (int i = 0; i < H; i++) begin
      @(negedge clock);
      check("show_st", io_out_o[37:36], exp_st);
      check("show_step", io_out_o[25:20], step);
      check("show_busy", busy_o, 1);
      if (i == 0) begin
        check("cap_err", la_err_o, cap_err);
        check("cap_last", la_last_o, step);
        la_step_i   = ~step;
        la_status_i = ~st;
      end
      if (pulse && i == 0) la_req_i = 1'b0;
      if (pulse && i == 1) la_req_i = 1'b1;
      if (pulse && i == 2) check("pulse_err", la_err_o, 1);
    end
    for (int i = 0; i < H; i++) begin
      @(negedge clock);
      check("clr_st", io_out_o[37:36], 0);
      check("clr_step", io_out_o[25:20], step);
      check("clr_ack", la_ack_o, 0);
      if (early && i == H - 1) la_req_i = 1'b0;
    end
    @(negedge clock);
    check("done_ack", la_ack_o, 1);
    if (!early) begin
      @(negedge clock);
      check("done_ack_hold", la_ack_o, 1);
      la_req_i = 1'b0;
    end
    @(negedge clock);
    check("idle_ack", la_ack_o, 0);
    check("idle_busy", busy_o, 0);
    check("idle_st", io_out_o[37:36], 0);
    check("idle_step", io_out_o[25:20], step);
    check("idle_pads", {io_out_o[35:26], io_out_o[19:0]}, 0);
  endtask

  task automatic check_reset_state();
    check("rst_out", io_out_o, 0);
    check("rst_oeb", io_oeb_o, oeb_exp);
    check("rst_ack", la_ack_o, 0);
    check("rst_err", la_err_o, 0);
    check("rst_last", la_last_o, 0);
    check("rst_busy", busy_o, 0);
  endtask

  task automatic do_reset(input logic req_lvl);
    @(negedge clock);
    resetb = 1'b0;
    #1;
    err_m  = 1'b0;
    last_m = '0;
    check_reset_state();
    @(negedge clock);
    @(negedge clock);
    la_req_i = req_lvl;
    resetb   = 1'b1;
  endtask

  initial begin
    oeb_exp = '1;
    oeb_exp[25:20] = 6'd0;
    oeb_exp[37:36] = 2'd0;
    resetb      = 1'b1;
    la_step_i   = '0;
    la_status_i = '0;
    la_req_i    = 1'b0;
    #2 resetb = 1'b0;
    #1 check_reset_state();
    @(negedge clock);
    @(negedge clock);
    resetb = 1'b1;

    for (int s = 1; s <= 63; s++) begin
      report(6'(s), 2'b11, 1'b0, 1'b0);
      if (s == 32) check("last_32", la_last_o, 32);
    end
    report(6'd0, 2'b11, 1'b0, 1'b0);
    report(6'd1, 2'b11, 1'b0, 1'b0);
    check("wrap_noerr", la_err_o, 0);

    report(6'd2, 2'b00, 1'b0, 1'b1);
    @(negedge clock);
    check("pulse_ack_low", la_ack_o, 0);

    @(posedge clock); #1;
    la_step_i   = 6'd3;
    la_status_i = 2'b10;
    la_req_i    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mid_show_st", io_out_o[37:36], 2'b10);
    @(negedge clock);
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("held_busy", busy_o, 0);
      check("held_out", io_out_o, 0);
      check("held_ack", la_ack_o, 0);
    end
    la_req_i = 1'b0;
    @(negedge clock);
    report(6'd1, 2'b10, 1'b0, 1'b0);
    check("post_rst_err", la_err_o, 0);
    report(6'd2, 2'b01, 1'b1, 1'b0);
    check("pulse_err_sticky", la_err_o, 1);

    do_reset(1'b0);
    report(6'd1, 2'b11, 1'b0, 1'b0);
    report(6'd2, 2'b11, 1'b0, 1'b0);
    check("seq_ok_err", la_err_o, 0);
    report(6'd4, 2'b11, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    check("skip_err_sticky", la_err_o, 1);
    check("skip_last", la_last_o, 4);
    check("skip_pad", io_out_o[25:20], 4);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
